bolt_return_ctrl: RTL and testbench
===================================

Name: bolt_return_ctrl

Overview:
- Downstream stage of the player bolt mover.
- Tracks the flight state of each of the 4 player bolts and gathers the pixel-level collision flags from the drawing/collision logic during each frame. It also detects bolts that have left the top of the screen.
- Produces the per-bolt boltReturn vector that the mover samples at startOfFrame, plus an alien-kill pulse/mask and a kill counter for the scoring block.

Parameters:
- NUM_BOLTS, 4, number of bolt slots; the RTL supports 4 only.
- TOP_LIMIT, 8, bolt Y (pixels) at or above which the bolt is off-screen.
- Y_WRAP, 480, bolt Y at or beyond this value is an underflowed/wrapped bolt and is treated as off-screen.
- CNT_W, 16, width of the kill counter.

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse at the start of each frame (30 Hz)
- boltFired  in  4  per-bolt launched flag from the mover
- boltY  in  44  bolt i top-left Y (unsigned) is at [11*i+10 : 11*i]
- boltHitAlien  in  4  per-bolt alien collision; may be high on many cycles of a frame
- boltHitShield  in  4  per-bolt shield collision; same style as boltHitAlien
- boltReturn  out  4  per-bolt return request to the mover; held for exactly one frame
- alienKill  out  1  one-cycle pulse when at least one alien hit is committed
- alienKillMask  out  4  bolts committing an alien hit; valid while alienKill=1, 0 otherwise
- killCount  out  CNT_W  saturating total of committed alien hits

Behaviour:
- Reset (async, resetN=0): all bolt FSMs go to IDLE. boltReturn=0, alienKill=0, alienKillMask=0, killCount=0. Pending flags are cleared. The boltFired edge register is cleared to 0.
- Per-bolt FSM states: IDLE, FLYING, HIT_PEND, RETURNING. Bolt i uses only its own bit/slice.
- IDLE -> FLYING on the rising edge of boltFired[i]; the edge is detected against a registered copy of boltFired.
- FLYING -> HIT_PEND on any cycle with boltHitAlien[i] or boltHitShield[i].
- FLYING -> HIT_PEND on a startOfFrame cycle where the bolt is off-screen. Off-screen means boltY_i <= TOP_LIMIT or boltY_i >= Y_WRAP.
- Hit reason is latched on entry to HIT_PEND. Priority is ALIEN > SHIELD > OFFSCREEN.
- A reason register is ORed with alien flags arriving later in the same frame. Alien wins even if a shield flag came first.
- HIT_PEND -> RETURNING on startOfFrame:
  - The FSM never leaves HIT_PEND in the same cycle it entered. A collision coincident with startOfFrame commits at the next startOfFrame.
  - boltReturn[i] goes to 1 on the cycle after the commit startOfFrame.
  - If the latched reason is ALIEN, alienKillMask[i] is set for that one cycle and alienKill is pulsed.
- RETURNING -> next state on the next startOfFrame:
  - boltReturn[i] drops to 0.
  - Goes to FLYING if boltFired[i]=1, because the mover relaunches from the player position; otherwise goes to IDLE.
  - The mover therefore sees boltReturn[i]=1 at exactly one startOfFrame sample.
- Collision flags are ignored in IDLE, HIT_PEND (except the alien reason upgrade) and RETURNING. Each flight yields at most one event.
- killCount += popcount(alienKillMask) on the alienKill cycle. Increment is 0..4, computed at CNT_W width. It saturates at 2^CNT_W-1 and never wraps.
- boltFired falling while FLYING or HIT_PEND: the FSM goes to IDLE immediately and drops any pending event.
- Every output is registered.

Optional Feature:
- Macro: BOLT_PIERCE_EN.
- Defined:
  - An alien hit does not move FLYING to HIT_PEND; the bolt keeps flying.
  - Each bolt commits at most one alien kill per frame, counted at the next startOfFrame through alienKill/alienKillMask.
  - Shield and off-screen events behave as normal.
- Undefined: behaviour is exactly as in Behaviour above.

Decomposition:
- Package bolt_pkg holds:
  - NUM_BOLTS, TOP_LIMIT and Y_WRAP defaults.
  - typedef enum logic[1:0] bolt_st_t {IDLE, FLYING, HIT_PEND, RETURNING}.
  - typedef enum logic[1:0] hit_rsn_t {NONE, ALIEN, SHIELD, OFFSCREEN}.
- Sub-module bolt_track_fsm holds one bolt's FSM, reason latch and return output. It is instantiated 4x in a generate loop.
- The top level holds the edge register, the kill mask/pulse and the popcount saturating counter.

Test Plan:
- Reset mid-flight: bolt 0 FLYING with a pending alien hit, resetN pulsed low -> all outputs 0, killCount=0, no boltReturn at the next startOfFrame.
- Alien kill: boltFired[1] rises, boltHitAlien[1] high for 5 cycles mid-frame -> at the next startOfFrame alienKill=1 for 1 cycle with mask 4'b0010 and killCount=1; boltReturn[1]=1 for exactly one frame.
- Off-screen: bolt 2 FLYING with boltY_2=5 at startOfFrame -> boltReturn[2]=1 one frame later; alienKill stays 0.
- Simultaneous: bolts 0 and 3 get alien hits in the same frame, bolt 3's coincident with startOfFrame -> first commit has mask 4'b0001; bolt 3 commits at the following startOfFrame with mask 4'b1000; killCount=2.
- Reason upgrade and saturation: shield hit then alien hit on bolt 0 in one frame -> commits as an alien kill. With CNT_W=2 and killCount=3, a further kill holds killCount at 3.
- BOLT_PIERCE_EN defined: bolt 0 hit by an alien in 2 consecutive frames -> two kills, boltReturn[0] stays 0 until off-screen.

Source files
------------

// File: rtl/bolt_pkg.sv
// Shared types and defaults for the player-bolt return controller.
// Optional build macro BOLT_PIERCE_EN: alien hits no longer end a flight;
// the bolt keeps flying and commits at most one alien kill per frame.
package bolt_pkg;

   localparam int NUM_BOLTS = 4;
   localparam int TOP_LIMIT = 8;
   localparam int Y_WRAP    = 480;
   localparam int Y_W       = 11;

`ifdef BOLT_PIERCE_EN
   localparam bit PIERCE_EN = 1'b1;
`else
   localparam bit PIERCE_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, FLYING, HIT_PEND, RETURNING} bolt_st_t;
   typedef enum logic [1:0] {NONE, ALIEN, SHIELD, OFFSCREEN} hit_rsn_t;

   // Number of set bits in a 4-bit bolt vector (0..4).
   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

endpackage

// File: rtl/bolt_track_fsm.sv
// One bolt's flight tracker: FSM, hit-reason latch and registered return
// request. Kill commit is a decode of the current state for the top level
// to register into the kill mask.
module bolt_track_fsm #(
   parameter int TOP_LIMIT = bolt_pkg::TOP_LIMIT,
   parameter int Y_WRAP    = bolt_pkg::Y_WRAP
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        sof_i,
   input  logic        fired_i,
   input  logic        fire_rise_i,
   input  logic        fire_fall_i,
   input  logic [10:0] y_i,
   input  logic        hit_alien_i,
   input  logic        hit_shield_i,
   output logic        return_o,
   output logic        kill_commit_o
);

   import bolt_pkg::*;

   localparam logic [10:0] TOP_Y  = 11'(TOP_LIMIT);
   localparam logic [10:0] WRAP_Y = 11'(Y_WRAP);

   bolt_st_t state_q;
   hit_rsn_t rsn_q;
   logic     return_q;
   logic     kill_pend_q;   // pierce mode only: alien hit seen this frame
   logic     offscreen_w;

   // Above the top limit or wrapped below zero both count as gone.
   assign offscreen_w = (y_i <= TOP_Y) || (y_i >= WRAP_Y);

   // A kill commits on the frame boundary that releases the bolt, or, in
   // pierce mode, on any frame boundary with an alien hit pending.
   assign kill_commit_o = sof_i & ~fire_fall_i &
                          ((((state_q == HIT_PEND) & ((rsn_q == ALIEN) | kill_pend_q))) |
                           ((state_q == FLYING) & kill_pend_q));

   assign return_o = return_q;

   // Per-bolt flight state machine with registered return request.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= IDLE;
         rsn_q       <= NONE;
         return_q    <= 1'b0;
         kill_pend_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               return_q    <= 1'b0;
               kill_pend_q <= 1'b0;
               if (fire_rise_i) begin
                  state_q <= FLYING;
                  rsn_q   <= NONE;
               end
            end
            FLYING: begin
               if (fire_fall_i) begin
                  state_q     <= IDLE;
                  rsn_q       <= NONE;
                  kill_pend_q <= 1'b0;
               end else begin
                  if (PIERCE_EN)
                     kill_pend_q <= sof_i ? hit_alien_i : (kill_pend_q | hit_alien_i);
                  if (!PIERCE_EN && hit_alien_i) begin
                     state_q <= HIT_PEND;
                     rsn_q   <= ALIEN;
                  end else if (hit_shield_i) begin
                     state_q <= HIT_PEND;
                     rsn_q   <= SHIELD;
                  end else if (sof_i && offscreen_w) begin
                     state_q <= HIT_PEND;
                     rsn_q   <= OFFSCREEN;
                  end
               end
            end
            HIT_PEND: begin
               if (fire_fall_i) begin
                  state_q     <= IDLE;
                  rsn_q       <= NONE;
                  kill_pend_q <= 1'b0;
               end else if (sof_i) begin
                  state_q     <= RETURNING;
                  return_q    <= 1'b1;
                  kill_pend_q <= 1'b0;
               end else if (hit_alien_i) begin
                  // a later alien hit in the same frame outranks shield/off-screen
                  rsn_q <= ALIEN;
               end
            end
            RETURNING: begin
               if (sof_i) begin
                  return_q <= 1'b0;
                  rsn_q    <= NONE;
                  state_q  <= fired_i ? FLYING : IDLE;
               end
            end
            default: begin
               state_q  <= IDLE;
               rsn_q    <= NONE;
               return_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/bolt_return_ctrl.sv
// Player bolt return controller: fire-edge register, one tracker per bolt,
// registered alien-kill pulse/mask and a saturating kill counter.
// Optional build macro BOLT_PIERCE_EN (see bolt_pkg).
module bolt_return_ctrl #(
   parameter int NUM_BOLTS = bolt_pkg::NUM_BOLTS,
   parameter int TOP_LIMIT = bolt_pkg::TOP_LIMIT,
   parameter int Y_WRAP    = bolt_pkg::Y_WRAP,
   parameter int CNT_W     = 16
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic                   startOfFrame,
   input  logic [NUM_BOLTS-1:0]   boltFired,
   input  logic [11*NUM_BOLTS-1:0] boltY,
   input  logic [NUM_BOLTS-1:0]   boltHitAlien,
   input  logic [NUM_BOLTS-1:0]   boltHitShield,
   output logic [NUM_BOLTS-1:0]   boltReturn,
   output logic                   alienKill,
   output logic [NUM_BOLTS-1:0]   alienKillMask,
   output logic [CNT_W-1:0]       killCount
);

   import bolt_pkg::*;

   localparam int SUM_W = CNT_W + 3;
   localparam logic [SUM_W-1:0] CNT_MAX = {{3{1'b0}}, {CNT_W{1'b1}}};

   logic [NUM_BOLTS-1:0] fired_q;
   logic [NUM_BOLTS-1:0] fire_rise_w;
   logic [NUM_BOLTS-1:0] fire_fall_w;
   logic [NUM_BOLTS-1:0] commit_w;
   logic [NUM_BOLTS-1:0] mask_q;
   logic                 kill_q;
   logic [CNT_W-1:0]     count_q;
   logic [SUM_W-1:0]     sum_w;

   assign fire_rise_w = boltFired & ~fired_q;
   assign fire_fall_w = ~boltFired & fired_q;

   for (genvar gi = 0; gi < NUM_BOLTS; gi++) begin : g_bolt
      bolt_track_fsm #(
         .TOP_LIMIT (TOP_LIMIT),
         .Y_WRAP    (Y_WRAP)
      ) u_fsm (
         .clk           (clk),
         .resetN        (resetN),
         .sof_i         (startOfFrame),
         .fired_i       (boltFired[gi]),
         .fire_rise_i   (fire_rise_w[gi]),
         .fire_fall_i   (fire_fall_w[gi]),
         .y_i           (boltY[11*gi +: 11]),
         .hit_alien_i   (boltHitAlien[gi]),
         .hit_shield_i  (boltHitShield[gi]),
         .return_o      (boltReturn[gi]),
         .kill_commit_o (commit_w[gi])
      );
   end

   // Wide enough that adding up to four kills can never wrap before saturation.
   assign sum_w = {3'b000, count_q} + SUM_W'(popcount4(mask_q));

   // Fire-edge history, registered kill pulse/mask, saturating kill total.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         fired_q <= '0;
         mask_q  <= '0;
         kill_q  <= 1'b0;
         count_q <= '0;
      end else begin
         fired_q <= boltFired;
         mask_q  <= commit_w;
         kill_q  <= |commit_w;
         if (kill_q)
            count_q <= (sum_w > CNT_MAX) ? {CNT_W{1'b1}} : sum_w[CNT_W-1:0];
      end
   end

   assign alienKill     = kill_q;
   assign alienKillMask = mask_q;
   assign killCount     = count_q;

endmodule

// File: tb/tb_bolt_return_ctrl.sv
// Directed bench for bolt_return_ctrl, built with a 2-bit kill counter so
// saturation is reachable. Build with BOLT_PIERCE_EN to exercise pierce mode.
module tb_bolt_return_ctrl;

   logic        clk = 1'b0;
   logic        resetN;
   logic        startOfFrame;
   logic [3:0]  boltFired;
   logic [43:0] boltY;
   logic [3:0]  boltHitAlien;
   logic [3:0]  boltHitShield;
   logic [3:0]  boltReturn;
   logic        alienKill;
   logic [3:0]  alienKillMask;
   logic [1:0]  killCount;

   int checks = 0;
   int errors = 0;

   bolt_return_ctrl #(.CNT_W(2)) dut (
      .clk           (clk),
      .resetN        (resetN),
      .startOfFrame  (startOfFrame),
      .boltFired     (boltFired),
      .boltY         (boltY),
      .boltHitAlien  (boltHitAlien),
      .boltHitShield (boltHitShield),
      .boltReturn    (boltReturn),
      .alienKill     (alienKill),
      .alienKillMask (alienKillMask),
      .killCount     (killCount)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic sof();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
   endtask

   task automatic set_y(input int idx, input logic [10:0] y);
      boltY[11*idx +: 11] = y;
   endtask

   task automatic chk_ret(input string name, input logic [3:0] exp);
      checks++;
      if (boltReturn !== exp) begin
         errors++;
         $display("FAIL %s boltReturn got %b expected %b", name, boltReturn, exp);
      end else
         $display("check %s boltReturn=%b ok", name, boltReturn);
   endtask

   task automatic chk_kill(input string name, input logic expk, input logic [3:0] expm);
      checks++;
      if (alienKill !== expk || alienKillMask !== expm) begin
         errors++;
         $display("FAIL %s alienKill/mask got %b/%b expected %b/%b",
                  name, alienKill, alienKillMask, expk, expm);
      end else
         $display("check %s alienKill=%b mask=%b ok", name, alienKill, alienKillMask);
   endtask

   task automatic chk_cnt(input string name, input logic [1:0] exp);
      checks++;
      if (killCount !== exp) begin
         errors++;
         $display("FAIL %s killCount got %0d expected %0d", name, killCount, exp);
      end else
         $display("check %s killCount=%0d ok", name, killCount);
   endtask

   task automatic test_reset();
      chk_ret("reset_ret", 4'b0000);
      chk_kill("reset_kill", 1'b0, 4'b0000);
      chk_cnt("reset_cnt", 2'd0);
      resetN = 1'b1;
      tick();
      // bolt 0 flying with a pending alien hit, then reset mid-flight
      boltFired = 4'b0001;
      tick();
      idle(2);
      boltHitAlien = 4'b0001;
      tick();
      boltHitAlien = 4'b0000;
      resetN = 1'b0;
      #2;
      chk_ret("midreset_ret", 4'b0000);
      chk_kill("midreset_kill", 1'b0, 4'b0000);
      resetN = 1'b1;
      tick();
      sof();
      chk_ret("midreset_sof1", 4'b0000);
      chk_kill("midreset_sof1", 1'b0, 4'b0000);
      idle(2);
      sof();
      chk_ret("midreset_sof2", 4'b0000);
      chk_cnt("midreset_cnt", 2'd0);
      boltFired = 4'b0000;
      tick();
      idle(2);
   endtask

   task automatic test_alien_kill();
      boltFired = 4'b0010;
      tick();
      idle(2);
      boltHitAlien = 4'b0010;
      idle(5);
      boltHitAlien = 4'b0000;
      idle(2);
      chk_ret("alien_pre", 4'b0000);
      sof();
      chk_kill("alien_commit", 1'b1, 4'b0010);
      chk_ret("alien_commit", 4'b0010);
      tick();
      chk_kill("alien_after", 1'b0, 4'b0000);
      chk_cnt("alien_cnt", 2'd1);
      idle(3);
      chk_ret("alien_hold", 4'b0010);
      boltFired = 4'b0000;
      tick();
      chk_ret("alien_hold_pre_sof", 4'b0010);
      sof();
      chk_ret("alien_release", 4'b0000);
      idle(2);
   endtask

   task automatic test_offscreen();
      logic [10:0] ys [6] = '{11'd5, 11'd8, 11'd9, 11'd479, 11'd480, 11'd2047};
      logic        ex [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int v = 0; v < 6; v++) begin
         set_y(2, ys[v]);
         boltFired = 4'b0100;
         tick();
         idle(2);
         sof();
         chk_ret($sformatf("off_y%0d_first", ys[v]), 4'b0000);
         idle(2);
         sof();
         chk_ret($sformatf("off_y%0d_commit", ys[v]), ex[v] ? 4'b0100 : 4'b0000);
         chk_kill($sformatf("off_y%0d_kill", ys[v]), 1'b0, 4'b0000);
         boltFired = 4'b0000;
         tick();
         sof();
         chk_ret($sformatf("off_y%0d_clear", ys[v]), 4'b0000);
         set_y(2, 11'd200);
         idle(2);
      end
   endtask

   task automatic test_simultaneous();
      boltFired = 4'b1001;
      tick();
      idle(2);
      boltHitAlien = 4'b0001;
      tick();
      boltHitAlien = 4'b0000;
      idle(2);
      boltHitAlien = 4'b1000;
      sof();
      boltHitAlien = 4'b0000;
      chk_kill("sim_first", 1'b1, 4'b0001);
      chk_ret("sim_first", 4'b0001);
      tick();
      chk_cnt("sim_cnt1", 2'd2);
      idle(2);
      sof();
      chk_kill("sim_second", 1'b1, 4'b1000);
      chk_ret("sim_second", 4'b1000);
      tick();
      chk_cnt("sim_cnt2", 2'd3);
      boltFired = 4'b0000;
      tick();
      sof();
      chk_ret("sim_clear", 4'b0000);
      idle(2);
   endtask

   task automatic test_upgrade_saturation();
      boltFired = 4'b0001;
      tick();
      idle(1);
      boltHitShield = 4'b0001;
      tick();
      boltHitShield = 4'b0000;
      idle(1);
      boltHitAlien = 4'b0001;
      tick();
      boltHitAlien = 4'b0000;
      idle(1);
      sof();
      chk_kill("upg_commit", 1'b1, 4'b0001);
      chk_ret("upg_commit", 4'b0001);
      tick();
      chk_cnt("sat_hold", 2'd3);
      boltFired = 4'b0000;
      tick();
      sof();
      chk_ret("upg_clear", 4'b0000);
      idle(2);
   endtask

   task automatic test_shield_only();
      logic [1:0] cnt_before;
      cnt_before = killCount;
      boltFired = 4'b0010;
      tick();
      boltHitShield = 4'b0010;
      tick();
      boltHitShield = 4'b0000;
      sof();
      chk_kill("shield_commit", 1'b0, 4'b0000);
      chk_ret("shield_commit", 4'b0010);
      tick();
      chk_cnt("shield_cnt", cnt_before);
      boltFired = 4'b0000;
      tick();
      sof();
      chk_ret("shield_clear", 4'b0000);
      idle(2);
   endtask

   task automatic test_fire_drop();
      boltFired = 4'b0100;
      tick();
      boltHitAlien = 4'b0100;
      tick();
      boltHitAlien = 4'b0000;
      boltFired = 4'b0000;
      tick();
      sof();
      chk_ret("drop_ret", 4'b0000);
      chk_kill("drop_kill", 1'b0, 4'b0000);
      idle(2);
   endtask

   task automatic test_pierce();
      boltFired = 4'b0001;
      tick();
      idle(1);
      boltHitAlien = 4'b0001;
      idle(2);
      boltHitAlien = 4'b0000;
      idle(1);
      sof();
      chk_kill("pierce_kill1", 1'b1, 4'b0001);
      chk_ret("pierce_ret1", 4'b0000);
      tick();
      chk_cnt("pierce_cnt1", 2'd1);
      boltHitAlien = 4'b0001;
      tick();
      boltHitAlien = 4'b0000;
      idle(1);
      sof();
      chk_kill("pierce_kill2", 1'b1, 4'b0001);
      chk_ret("pierce_ret2", 4'b0000);
      tick();
      chk_cnt("pierce_cnt2", 2'd2);
      set_y(0, 11'd5);
      sof();
      chk_ret("pierce_off1", 4'b0000);
      idle(1);
      sof();
      chk_ret("pierce_off2", 4'b0001);
      chk_kill("pierce_off2", 1'b0, 4'b0000);
      boltFired = 4'b0000;
      tick();
      sof();
      set_y(0, 11'd200);
      chk_ret("pierce_clear", 4'b0000);
      idle(2);
   endtask

   initial begin
      resetN        = 1'b0;
      startOfFrame  = 1'b0;
      boltFired     = 4'b0000;
      boltHitAlien  = 4'b0000;
      boltHitShield = 4'b0000;
      boltY         = {4{11'd200}};
      idle(2);
      test_reset();
`ifdef BOLT_PIERCE_EN
      test_offscreen();
      test_shield_only();
      test_fire_drop();
      test_pierce();
`else
      test_alien_kill();
      test_offscreen();
      test_simultaneous();
      test_upgrade_saturation();
      test_shield_only();
      test_fire_drop();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
